// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the multi-cycle MIPS CPU.
//
// Holds the PC and drives it as the instruction-ROM address. When the controller
// raises IF_valid, the stage waits MEM_LATENCY cycles for the synchronous ROM, captures
// the returned word, and raises IF_over with {pc, inst_r} on IF_ID_bus. A next_fetch
// pulse advances the PC (sequential or to the decode-stage jump/branch target) and
// returns the stage to idle.
//
// Parameters:
//   STARTADDR    PC value loaded on reset.
//   MEM_LATENCY  cycles from a stable inst_addr to valid inst data (1..4).
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   IF_valid    fetch enable from the controller (level)
//   next_fetch  one-cycle pulse: advance the PC
//   jbr_bus     {jbr_taken, jbr_target[31:0]} from decode
//   inst_addr   instruction-ROM address (= pc)
//   inst        instruction-ROM read data
//   IF_over     fetch complete, IF_ID_bus valid
//   IF_ID_bus   {pc, inst_r}
//   IF_pc       current PC (display)
//   IF_inst     captured instruction (display)
//   IF_adel     address-error flag, only when IF_ADDR_CHECK_EN is defined
//
// Optional feature macro: IF_ADDR_CHECK_EN. When defined, a fetch from a misaligned
// PC captures a NOP and raises IF_adel instead of using the ROM data.

module fetch_stage #(
    parameter logic [31:0] STARTADDR   = 32'h0000_0000,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IF_valid,
    input  logic        next_fetch,
    input  logic [32:0] jbr_bus,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst,
    output logic        IF_over,
    output logic [63:0] IF_ID_bus,
    output logic [31:0] IF_pc,
    output logic [31:0] IF_inst
`ifdef IF_ADDR_CHECK_EN
    ,
    output logic        IF_adel
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Last WAIT count before capture; cnt is wide enough for latencies up to 4.
    localparam logic [1:0] CNT_LAST = 2'(MEM_LATENCY - 1);

    logic [31:0] pc;
    logic [31:0] inst_r;
    logic [1:0]  state;
    logic [1:0]  cnt;

    logic        jbr_taken;
    logic [31:0] jbr_target;

    assign jbr_taken  = jbr_bus[32];
    assign jbr_target = jbr_bus[31:0];

`ifdef IF_ADDR_CHECK_EN
    logic adel;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= STARTADDR;
            inst_r <= 32'd0;
            state  <= IDLE;
            cnt    <= 2'd0;
`ifdef IF_ADDR_CHECK_EN
            adel   <= 1'b0;
`endif
        end else if (next_fetch) begin
            // next_fetch overrides any fetch in progress, including one requested
            // in this same cycle; pc + 4 wraps naturally at 32 bits.
            pc    <= jbr_taken ? jbr_target : pc + 32'd4;
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (IF_valid) begin
                        state <= WAIT;
                        cnt   <= 2'd0;
                    end
                end
                WAIT: begin
                    if (!IF_valid) begin
                        // Aborted fetch: inst_r keeps its old value.
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
`ifdef IF_ADDR_CHECK_EN
                        if (pc[1:0] != 2'b00) begin
                            inst_r <= 32'd0;
                            adel   <= 1'b1;
                        end else begin
                            inst_r <= inst;
                            adel   <= 1'b0;
                        end
`else
                        inst_r <= inst;
`endif
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                DONE: begin
                    if (!IF_valid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign inst_addr = pc;
    assign IF_over   = (state == DONE);
    assign IF_ID_bus = {pc, inst_r};
    assign IF_pc     = pc;
    assign IF_inst   = inst_r;

`ifdef IF_ADDR_CHECK_EN
    assign IF_adel = adel;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage.
//
// Two instances share all stimulus: one with MEM_LATENCY=1, one with MEM_LATENCY=3.
// Each has its own one-cycle synchronous ROM model. The stimulus process pushes the
// expected {rise cycle, IF_ID_bus, IF_adel} of every fetch into a per-instance queue;
// a monitor pops and compares on every rising edge of IF_over. Spot checks of
// inst_addr / IF_over / IF_inst are made directly by the stimulus.

module tb_fetch_stage;

    localparam int ML1 = 1;
    localparam int ML3 = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        IF_valid = 1'b0;
    logic        next_fetch = 1'b0;
    logic [32:0] jbr_bus = '0;

    logic [31:0] addr1, addr3, inst1, inst3, pc1, pc3, ins1, ins3;
    logic        over1, over3;
    logic [63:0] bus1, bus3;
    logic        adel1, adel3;

    int cyc    = 0;
    int n_vec  = 0;
    int n_err  = 0;

    typedef struct {
        int          cyc;
        logic [63:0] bus;
        logic        adel;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];

    logic prev1 = 1'b0;
    logic prev3 = 1'b0;

    fetch_stage #(.STARTADDR(32'h0000_0000), .MEM_LATENCY(ML1)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .IF_valid   (IF_valid),
        .next_fetch (next_fetch),
        .jbr_bus    (jbr_bus),
        .inst_addr  (addr1),
        .inst       (inst1),
        .IF_over    (over1),
        .IF_ID_bus  (bus1),
        .IF_pc      (pc1),
        .IF_inst    (ins1)
`ifdef IF_ADDR_CHECK_EN
        ,
        .IF_adel    (adel1)
`endif
    );

    fetch_stage #(.STARTADDR(32'h0000_0000), .MEM_LATENCY(ML3)) u_dut3 (
        .clk        (clk),
        .reset      (reset),
        .IF_valid   (IF_valid),
        .next_fetch (next_fetch),
        .jbr_bus    (jbr_bus),
        .inst_addr  (addr3),
        .inst       (inst3),
        .IF_over    (over3),
        .IF_ID_bus  (bus3),
        .IF_pc      (pc3),
        .IF_inst    (ins3)
`ifdef IF_ADDR_CHECK_EN
        ,
        .IF_adel    (adel3)
`endif
    );

`ifndef IF_ADDR_CHECK_EN
    assign adel1 = 1'b0;
    assign adel3 = 1'b0;
`endif

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: rom_word = 32'h2401_0001;
            32'h0000_0004: rom_word = 32'h0022_1821;
            32'h0000_0040: rom_word = 32'h3C08_ABCD;
            32'h0000_0042: rom_word = 32'h1111_2222;
            32'h0000_0044: rom_word = 32'h8D09_0004;
            default:       rom_word = 32'hDEAD_BEEF;
        endcase
    endfunction

    // Synchronous ROMs and the cycle counter (cyc = number of rising edges so far).
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        inst1 <= rom_word(addr1);
        inst3 <= rom_word(addr3);
    end

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int id, input logic over, input logic prev,
                       input logic [63:0] bus, input logic adel);
        exp_t e;
        if (over && !prev) begin
            if (id == 1 && q1.size() > 0) begin
                e = q1.pop_front();
            end else if (id == 3 && q3.size() > 0) begin
                e = q3.pop_front();
            end else begin
                n_vec++;
                n_err++;
                $display("FAIL dut%0d unexpected fetch: got IF_over rise at cycle %0d bus %h, want none",
                         id, cyc, bus);
                return;
            end
            check($sformatf("dut%0d IF_over rise cycle", id), 65'(cyc), 65'(e.cyc));
            check($sformatf("dut%0d IF_ID_bus/IF_adel", id), {bus, adel}, {e.bus, e.adel});
        end
    endtask

    always @(negedge clk) begin
        mon(1, over1, prev1, bus1, adel1);
        mon(3, over3, prev3, bus3, adel3);
        prev1 <= over1;
        prev3 <= over3;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // first = cycle number of the edge that samples IF_valid=1 in IDLE.
    task automatic push(input int first, input logic [31:0] pc, input logic [31:0] ins,
                        input logic adel, input bit on1, input bit on3);
        exp_t e;
        e.bus  = {pc, ins};
        e.adel = adel;
        if (on1) begin
            e.cyc = first + ML1;
            q1.push_back(e);
        end
        if (on3) begin
            e.cyc = first + ML3;
            q3.push_back(e);
        end
    endtask

    initial begin
        // Reset held for two cycles.
        tick();
        tick();
        check("reset inst_addr", 65'(addr1), 65'h0);
        check("reset IF_over", 65'(over1), 65'h0);
        check("reset IF_ID_bus dut1", 65'(bus1), 65'h0);
        check("reset IF_ID_bus dut3", 65'(bus3), 65'h0);
        reset = 1'b0;

        // Basic fetch from address 0, IF_valid held.
        IF_valid = 1'b1;
        push(cyc + 1, 32'h0, 32'h2401_0001, 1'b0, 1'b1, 1'b1);
        repeat (6) tick();
        check("DONE holds IF_over", 65'(over1), 65'h1);
        check("DONE holds bus dut1", 65'(bus1), 65'h00000000_24010001);
        check("DONE holds bus dut3", 65'(bus3), 65'h00000000_24010001);

        // Sequential advance from DONE with IF_valid still high: refetch at 4.
        next_fetch = 1'b1;
        jbr_bus    = {1'b0, 32'h0};
        push(cyc + 2, 32'h4, 32'h0022_1821, 1'b0, 1'b1, 1'b1);
        tick();
        next_fetch = 1'b0;
        check("pc+4 inst_addr", 65'(addr1), 65'h4);
        check("IF_over drops after next_fetch", 65'(over1), 65'h0);
        repeat (6) tick();
        check("refetch bus dut1", 65'(bus1), 65'h00000004_00221821);
        IF_valid = 1'b0;
        tick();
        check("IF_over drops with IF_valid dut1", 65'(over1), 65'h0);
        check("IF_over drops with IF_valid dut3", 65'(over3), 65'h0);

        // Branch taken with IF_valid raised in the same cycle: next_fetch wins.
        IF_valid   = 1'b1;
        next_fetch = 1'b1;
        jbr_bus    = {1'b1, 32'h0000_0040};
        push(cyc + 2, 32'h40, 32'h3C08_ABCD, 1'b0, 1'b1, 1'b1);
        tick();
        next_fetch = 1'b0;
        jbr_bus    = '0;
        check("branch inst_addr", 65'(addr1), 65'h40);
        check("no fetch with next_fetch", 65'(over1), 65'h0);
        repeat (6) tick();
        IF_valid = 1'b0;
        tick();

        // Advance to 0x44, then abort dut3 in its second WAIT cycle.
        next_fetch = 1'b1;
        tick();
        next_fetch = 1'b0;
        check("pc+4 after branch", 65'(addr3), 65'h44);
        IF_valid = 1'b1;
        push(cyc + 1, 32'h44, 32'h8D09_0004, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        IF_valid = 1'b0;
        repeat (4) tick();
        check("abort keeps IF_inst dut3", 65'(ins3), 65'h3C08ABCD);
        check("abort no IF_over dut3", 65'(over3), 65'h0);
        check("short latency captured dut1", 65'(ins1), 65'h8D090004);

        // PC wrap; the target of a not-taken bus must be ignored.
        next_fetch = 1'b1;
        jbr_bus    = {1'b1, 32'hFFFF_FFFC};
        tick();
        check("jump to top inst_addr", 65'(addr1), 65'hFFFFFFFC);
        jbr_bus = {1'b0, 32'h0000_0080};
        tick();
        next_fetch = 1'b0;
        jbr_bus    = '0;
        check("pc wrap inst_addr", 65'(addr1), 65'h0);

        // Reset during WAIT with pc = 0x40.
        next_fetch = 1'b1;
        jbr_bus    = {1'b1, 32'h0000_0040};
        tick();
        next_fetch = 1'b0;
        jbr_bus    = '0;
        IF_valid   = 1'b1;
        tick();
        reset    = 1'b1;
        IF_valid = 1'b0;
        tick();
        reset = 1'b0;
        check("mid-fetch reset inst_addr", 65'(addr1), 65'h0);
        check("mid-fetch reset IF_over", 65'(over1), 65'h0);
        check("mid-fetch reset IF_inst", 65'(ins1), 65'h0);
        check("mid-fetch reset bus dut3", 65'(bus3), 65'h0);
        repeat (5) tick();
        check("no fetch after reset", 65'(over3), 65'h0);

        // Misaligned fetch from 0x42.
        next_fetch = 1'b1;
        jbr_bus    = {1'b1, 32'h0000_0042};
        tick();
        next_fetch = 1'b0;
        jbr_bus    = '0;
        check("misaligned inst_addr", 65'(addr1), 65'h42);
        IF_valid = 1'b1;
`ifdef IF_ADDR_CHECK_EN
        push(cyc + 1, 32'h42, 32'h0, 1'b1, 1'b1, 1'b1);
`else
        push(cyc + 1, 32'h42, 32'h1111_2222, 1'b0, 1'b1, 1'b1);
`endif
        repeat (6) tick();
`ifdef IF_ADDR_CHECK_EN
        check("IF_adel held dut3", 65'(adel3), 65'h1);
        check("NOP captured dut3", 65'(ins3), 65'h0);
`else
        check("misaligned captured dut3", 65'(ins3), 65'h11112222);
`endif
        IF_valid = 1'b0;
        repeat (3) tick();

        // Every pushed expectation must have been consumed by the monitor.
        while (q1.size() > 0) begin
            exp_t e;
            e = q1.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL dut1 missing fetch: got no IF_over rise, want one at cycle %0d bus %h",
                     e.cyc, e.bus);
        end
        while (q3.size() > 0) begin
            exp_t e;
            e = q3.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL dut3 missing fetch: got no IF_over rise, want one at cycle %0d bus %h",
                     e.cyc, e.bus);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
